// File: rtl/wrr_arbiter.sv
// wrr_arbiter: four-requester weighted round-robin arbiter.
// Each grant is held for up to max(weight,1) cycles. Rotation continues from the
// requester after the one that last released.
// Optional feature macro: WRR_LOCK_EN. When defined, 'lock' keeps the current grant
// past credit expiry for as long as that requester keeps requesting.
module wrr_arbiter #(
    parameter int CW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*CW-1:0] weight_cfg,
    input  logic            cfg_load,
    input  logic            lock,
    output logic [3:0]      gnt,
    output logic [1:0]      gnt_id,
    output logic            busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [1:0]     gnt_id_q, gnt_id_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [CW-1:0]  credit_q, credit_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  weight_q [4];

    logic           doArb;
    logic [1:0]     arbPtr;
    logic [1:0]     winner;
    logic           holdLock;
    logic           releaseGrant;

`ifndef WRR_LOCK_EN
    // Without the lock feature the input has no effect on the grant logic.
    logic lock_unused;
    assign lock_unused = lock;
`endif

    // First set request bit, scanning circularly upward starting at p.
    function automatic logic [1:0] pickWinner(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // A programmed weight of zero still earns one cycle of grant.
    function automatic logic [CW-1:0] effWeight(input logic [CW-1:0] w);
        return (w == '0) ? CW'(1) : w;
    endfunction

    // Weight registers: reset to 1, reloaded whenever cfg_load is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                weight_q[i] <= CW'(1);
            end
        end else if (cfg_load) begin
            for (int i = 0; i < 4; i++) begin
                weight_q[i] <= weight_cfg[i*CW +: CW];
            end
        end
    end

    // Next-state logic: grant hold/release, credit count and same-edge re-arbitration.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gnt_id_d     = gnt_id_q;
        ptr_d        = ptr_q;
        credit_d     = credit_q;
        doArb        = 1'b0;
        arbPtr       = ptr_q;
        winner       = 2'd0;
        holdLock     = 1'b0;
        releaseGrant = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    doArb = 1'b1;
                end
            end
            GRANT: begin
`ifdef WRR_LOCK_EN
                holdLock = lock && req[gnt_id_q];
`endif
                if (!req[gnt_id_q]) begin
                    releaseGrant = 1'b1;
                end else if (credit_q == CW'(1)) begin
                    releaseGrant = !holdLock;
                end else begin
                    credit_d = credit_q - CW'(1);
                end

                if (releaseGrant) begin
                    // The releasing requester goes to the back of the rotation.
                    ptr_d  = gnt_id_q + 2'd1;
                    arbPtr = gnt_id_q + 2'd1;
                    if (|req) begin
                        doArb = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = 4'b0000;
                        credit_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase

        if (doArb) begin
            winner   = pickWinner(req, arbPtr);
            state_d  = GRANT;
            gnt_d    = 4'b0001 << winner;
            gnt_id_d = winner;
            credit_d = effWeight(weight_q[winner]);
        end

        busy_d = (gnt_d != 4'b0000);
    end

    // State, grant and pointer registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            ptr_q    <= 2'd0;
            credit_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter: directed self-checking bench for wrr_arbiter (CW = 4).
module tb_wrr_arbiter;

    localparam int CW = 4;

    logic            clk;
    logic            rst;
    logic [3:0]      req;
    logic [4*CW-1:0] weight_cfg;
    logic            cfg_load;
    logic            lock;
    logic [3:0]      gnt;
    logic [1:0]      gnt_id;
    logic            busy;

    int testsRun;
    int testsFailed;

    wrr_arbiter #(.CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .weight_cfg (weight_cfg),
        .cfg_load   (cfg_load),
        .lock       (lock),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle a little past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        req      = 4'b0000;
        cfg_load = 1'b0;
        lock     = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Reset clears outputs and beats a simultaneous cfg_load and requests.
    task automatic test_reset();
        logic [3:0] expSeq [4];
        expSeq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        rst        = 1'b1;
        cfg_load   = 1'b1;
        weight_cfg = 16'h3333;
        req        = 4'b1111;
        lock       = 1'b0;
        tick();
        testsRun++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: gnt=%b busy=%b id=%0d expected 0000 0 0", gnt, busy, gnt_id);
        end
        rst      = 1'b0;
        cfg_load = 1'b0;
        req      = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            testsRun++;
            if (gnt !== expSeq[i] || busy !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL reset_weights[%0d]: gnt=%b busy=%b expected %b 1", i, gnt, busy, expSeq[i]);
            end
        end
        req = 4'b0000;
        tick();
        testsRun++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_idle: gnt=%b busy=%b expected 0000 0", gnt, busy);
        end
    endtask

    // A single requester with weight 1 is re-granted every cycle.
    task automatic test_single();
        doReset();
        req = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if (gnt !== 4'b1000 || gnt_id !== 2'd3 || busy !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL single[%0d]: gnt=%b id=%0d busy=%b expected 1000 3 1", i, gnt, gnt_id, busy);
            end
        end
        req = 4'b0000;
        tick();
        testsRun++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_idle: gnt=%b busy=%b expected 0000 0", gnt, busy);
        end
    endtask

    // Equal weights rotate through all requesters with no idle bubble.
    task automatic test_round_robin();
        logic [3:0] expSeq [5];
        logic [1:0] expId  [5];
        expSeq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        expId  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        doReset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            testsRun++;
            if (gnt !== expSeq[i] || gnt_id !== expId[i] || busy !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL round_robin[%0d]: gnt=%b id=%0d busy=%b expected %b %0d 1",
                         i, gnt, gnt_id, busy, expSeq[i], expId[i]);
            end
        end
    endtask

    // Weights {3,1,2,1} shape the grant pattern.
    task automatic test_weights();
        logic [3:0] expSeq [11];
        expSeq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0100,
                   4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        doReset();
        weight_cfg = 16'h1213;
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        req      = 4'b1111;
        for (int i = 0; i < 11; i++) begin
            tick();
            testsRun++;
            if (gnt !== expSeq[i]) begin
                testsFailed++;
                $display("[TB] FAIL weights[%0d]: gnt=%b expected %b", i, gnt, expSeq[i]);
            end
        end
    endtask

    // Weight 0 acts as 1; a reload during a grant only affects the next credit load.
    task automatic test_weight_update();
        logic [3:0] expZero [3];
        logic [3:0] expLoad [6];
        expZero = '{4'b0001, 4'b0010, 4'b0001};
        expLoad = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
        doReset();
        weight_cfg = 16'h1110;
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        req      = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if (gnt !== expZero[i]) begin
                testsFailed++;
                $display("[TB] FAIL weight_zero[%0d]: gnt=%b expected %b", i, gnt, expZero[i]);
            end
        end
        doReset();
        weight_cfg = 16'h1113;
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        req      = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                weight_cfg = 16'h1111;
                cfg_load   = 1'b1;
            end else begin
                cfg_load = 1'b0;
            end
            tick();
            testsRun++;
            if (gnt !== expLoad[i]) begin
                testsFailed++;
                $display("[TB] FAIL weight_inflight[%0d]: gnt=%b expected %b", i, gnt, expLoad[i]);
            end
        end
    endtask

    // Dropping the granted request releases early; pointer moves past it.
    task automatic test_early_release();
        doReset();
        weight_cfg = 16'h1141;
        cfg_load   = 1'b1;
        tick();
        cfg_load = 1'b0;
        req      = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            tick();
            testsRun++;
            if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
                testsFailed++;
                $display("[TB] FAIL early_hold[%0d]: gnt=%b id=%0d expected 0010 1", i, gnt, gnt_id);
            end
        end
        req = 4'b0000;
        tick();
        testsRun++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL early_release: gnt=%b busy=%b expected 0000 0", gnt, busy);
        end
        req = 4'b1111;
        tick();
        testsRun++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            testsFailed++;
            $display("[TB] FAIL early_ptr: gnt=%b id=%0d expected 0100 2", gnt, gnt_id);
        end
    endtask

    // A request withdrawn before it is served is never granted.
    task automatic test_dropped_request();
        doReset();
        req = 4'b0011;
        tick();
        testsRun++;
        if (gnt !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL drop_first: gnt=%b expected 0001", gnt);
        end
        req = 4'b0001;
        tick();
        testsRun++;
        if (gnt !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL drop_regrant: gnt=%b expected 0001", gnt);
        end
        req = 4'b0000;
        tick();
        testsRun++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL drop_idle: gnt=%b busy=%b expected 0000 0", gnt, busy);
        end
    endtask

    // Reset in the middle of a grant drops it at once and restores priority 0 first.
    task automatic test_midgrant_reset();
        doReset();
        req = 4'b0100;
        tick();
        testsRun++;
        if (gnt !== 4'b0100) begin
            testsFailed++;
            $display("[TB] FAIL midreset_grant: gnt=%b expected 0100", gnt);
        end
        rst = 1'b1;
        tick();
        testsRun++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_drop: gnt=%b busy=%b expected 0000 0", gnt, busy);
        end
        rst = 1'b0;
        req = 4'b1111;
        tick();
        testsRun++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_first: gnt=%b id=%0d expected 0001 0", gnt, gnt_id);
        end
    endtask

    // Lock extends a grant only when the feature is built in.
    task automatic test_lock();
        logic [3:0] expSeq [6];
`ifdef WRR_LOCK_EN
        expSeq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
`else
        expSeq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
`endif
        doReset();
        req  = 4'b0011;
        lock = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                lock = 1'b0;
            end
            tick();
            testsRun++;
            if (gnt !== expSeq[i]) begin
                testsFailed++;
                $display("[TB] FAIL lock[%0d]: gnt=%b expected %b", i, gnt, expSeq[i]);
            end
        end
        lock = 1'b1;
        req  = 4'b0001;
        tick();
        testsRun++;
        if (gnt !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL lock_release: gnt=%b expected 0001", gnt);
        end
        lock = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        req         = 4'b0000;
        weight_cfg  = '0;
        cfg_load    = 1'b0;
        lock        = 1'b0;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_weights();
        test_weight_update();
        test_early_release();
        test_dropped_request();
        test_midgrant_reset();
        test_lock();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 Parameter: CW, 4, credit/weight field width per requester; the block SHALL support CW from 2 to 8.
REQ-002 Port: clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: req  input  4  request per requester, level-sensitive, bit i = requester i.
REQ-005 Port: weight_cfg  input  4*CW  weights; field i is bits [i*CW +: CW].
REQ-006 Port: cfg_load  input  1  when high at an edge, weight_cfg SHALL be captured into the internal weight registers.
REQ-007 Port: lock  input  1  grant-extension request; it SHALL be used only when WRR_LOCK_EN is defined.
REQ-008 Port: gnt  output  4  registered grant, one-hot or zero.
REQ-009 Port: gnt_id  output  2  registered index of the granted requester; it SHALL be valid only while busy=1.
REQ-010 Port: busy  output  1  registered; high exactly when gnt is nonzero.

Function
REQ-011 The FSM SHALL have two states: IDLE (gnt=0) and GRANT (gnt=1<<gnt_id).
REQ-012 IDLE: at an edge with req!=0, the FSM SHALL go to GRANT; the winner SHALL be the first set req bit scanning circularly from ptr; gnt SHALL be visible one cycle after req is sampled.
REQ-013 On each grant, credit SHALL load with weight[winner]; a weight of 0 SHALL be treated as 1.
REQ-014 GRANT, at each edge: if req[gnt_id]=0 or credit==1, the grant SHALL be released; otherwise credit SHALL decrement by 1 and the grant SHALL hold.
REQ-015 On release, ptr SHALL become (gnt_id+1) mod 4.
REQ-016 On release, if any req bit is set, the block SHALL re-arbitrate in the same edge from the new ptr and stay in GRANT with no idle bubble; the releasing requester SHALL be eligible, with lowest priority.
REQ-017 On release with req=0, the FSM SHALL go to IDLE, and gnt and busy SHALL clear.
REQ-018 A held grant SHALL therefore last at most max(weight,1) cycles.
REQ-019 Weight registers SHALL update on any cycle when cfg_load=1; a new weight SHALL apply only at the next credit load, and an in-flight credit SHALL be unaffected.
REQ-020 Requests that drop before being granted SHALL be ignored.
REQ-021 gnt SHALL never have more than one bit set.
REQ-022 gnt SHALL never assert a bit whose req was 0 at the deciding edge.

Reset
REQ-023 When rst=1 at an edge, the block SHALL set: state=IDLE, gnt=4'b0000, gnt_id=0, busy=0, ptr=0, credit=0, all weights=1.
REQ-024 Reset SHALL take priority over cfg_load and every request.
REQ-025 Reset asserted mid-grant SHALL drop gnt at that edge.
REQ-026 After reset deasserts, the first arbitration SHALL use priority order 0,1,2,3.

Configuration
REQ-027 The macro name SHALL be WRR_LOCK_EN.
REQ-028 With WRR_LOCK_EN defined: while lock=1 and req[gnt_id]=1, credit expiry SHALL be suppressed (credit held at 1, grant held); release on req[gnt_id]=0 SHALL be unchanged.
REQ-029 With WRR_LOCK_EN undefined: lock SHALL be ignored and behaviour SHALL be exactly REQ-011 to REQ-022.

Verification
REQ-030 After reset, req=1000 -> gnt=1000 one cycle later; it SHALL hold 1 cycle (weight 1), then re-grant 1000 while req remains 1000.
REQ-031 All weights=1, req=1111 held -> gnt sequence 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-032 cfg_load with weights {3,1,2,1} (req0..req3), req=1111 -> 0001 x3, 0010 x1, 0100 x2, 1000 x1, repeating.
REQ-033 Weight 4 on req1, req=0010 granted, req1 drops after 2 cycles -> release after 2 cycles; ptr=2; with req=0000 -> IDLE, busy=0.
REQ-034 rst=1 during a grant of 0100 -> gnt=0000 at that edge; next req=1111 -> 0001 granted first.
REQ-035 WRR_LOCK_EN defined, weight 1, req=0011, lock=1 for 5 cycles while 0001 granted -> 0001 held 5 cycles, then 0010 on the cycle after lock drops; WRR_LOCK_EN undefined, same stimulus -> alternation 0001,0010.
